// File: rtl/ir_pkg.sv
// Shared types and command codes for the IR remote command decoder.
package ir_pkg;

    typedef enum logic [2:0] {
        MOTION_STOP  = 3'd0,
        MOTION_FWD   = 3'd1,
        MOTION_LEFT  = 3'd2,
        MOTION_RIGHT = 3'd3
    } motion_t;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } hold_state_t;

    localparam logic [7:0] IR_CODE_STOP   = 8'h0C;
    localparam logic [7:0] IR_CODE_FWD    = 8'h16;
    localparam logic [7:0] IR_CODE_LEFT   = 8'h14;
    localparam logic [7:0] IR_CODE_RIGHT  = 8'h18;
    localparam logic [7:0] IR_CODE_FAST   = 8'h1B;
    localparam logic [7:0] IR_CODE_SLOW   = 8'h1F;
    localparam logic [7:0] IR_CODE_TOGGLE = 8'h12;

    // Codes that latch as last_cmd and can be re-applied by a repeat.
    function automatic logic is_hold_code(input logic [7:0] code);
        return (code == IR_CODE_FWD)  || (code == IR_CODE_LEFT) ||
               (code == IR_CODE_RIGHT) || (code == IR_CODE_FAST) ||
               (code == IR_CODE_SLOW);
    endfunction

endpackage

// File: rtl/ir_hold_timer.sv
// Key-hold timer: cleared on restart, counts while run is high, flags the last hold cycle.
module ir_hold_timer #(
    parameter int TIMEOUT_CYCLES = 5_400_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign expire = run && (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (!run) begin
            count_d = '0;
        end else if (!expire) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ir_cmd_decoder.sv
// IR remote command decoder: NEC frames/repeats to motion, speed level and mode.
// Define IR_CMD_CHECK_EN to require a valid complement byte and matching address.
module ir_cmd_decoder
    import ir_pkg::*;
#(
    parameter int          SPEED_LEVELS   = 4,
    parameter int          SPEED_RESET    = 0,
    parameter int          TIMEOUT_CYCLES = 5_400_000,
    parameter logic [15:0] ADDR           = 16'h00FF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [31:0]                     ir_data,
    input  logic                            data_ready,
    input  logic                            ir_repeat,
    output motion_t                         motion,
    output logic [$clog2(SPEED_LEVELS)-1:0] speed,
    output logic                            auto_mode,
    output logic                            cmd_valid,
    output logic                            cmd_error
);
    localparam int SW = $clog2(SPEED_LEVELS);
    localparam logic [SW-1:0] SPEED_MAX  = SW'(SPEED_LEVELS - 1);
    localparam logic [SW-1:0] SPEED_INIT = SW'(SPEED_RESET);

    hold_state_t   state_q, state_d;
    motion_t       motion_q, motion_d;
    logic [SW-1:0] speed_q, speed_d;
    logic          auto_q, auto_d;
    logic [7:0]    last_q, last_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;

    logic       restart, expire, frame_ok, apply;
    logic [7:0] code, apply_code;

    assign code = ir_data[7:0];

`ifdef IR_CMD_CHECK_EN
    assign frame_ok = (ir_data[15:8] == ~ir_data[7:0]) && (ir_data[31:16] == ADDR);
`else
    logic unused_bits;
    assign unused_bits = ^{ir_data[31:8], ADDR};
    assign frame_ok    = 1'b1;
`endif

    ir_hold_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .run     (state_q == HELD),
        .expire  (expire)
    );

    // A frame outranks a simultaneous repeat, and any strobe outranks expiry.
    always_comb begin
        state_d    = state_q;
        motion_d   = motion_q;
        speed_d    = speed_q;
        auto_d     = auto_q;
        last_d     = last_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        restart    = 1'b0;
        apply      = 1'b0;
        apply_code = code;

        if (data_ready) begin
            if (!frame_ok || !(is_hold_code(code) || code == IR_CODE_STOP ||
                               code == IR_CODE_TOGGLE)) begin
                motion_d = MOTION_STOP;
                state_d  = IDLE;
                error_d  = 1'b1;
            end else if (code == IR_CODE_STOP) begin
                motion_d = MOTION_STOP;
                state_d  = IDLE;
                valid_d  = 1'b1;
            end else if (code == IR_CODE_TOGGLE) begin
                auto_d   = !auto_q;
                motion_d = MOTION_STOP;
                state_d  = IDLE;
                valid_d  = 1'b1;
            end else if (!auto_q) begin
                apply = 1'b1;
            end
        end else if (ir_repeat && state_q == HELD && !auto_q) begin
            apply      = 1'b1;
            apply_code = last_q;
        end else if (expire) begin
            motion_d = MOTION_STOP;
            state_d  = IDLE;
        end

        if (apply) begin
            last_d  = apply_code;
            state_d = HELD;
            restart = 1'b1;
            valid_d = 1'b1;
            case (apply_code)
                IR_CODE_FWD:   motion_d = MOTION_FWD;
                IR_CODE_LEFT:  motion_d = MOTION_LEFT;
                IR_CODE_RIGHT: motion_d = MOTION_RIGHT;
                IR_CODE_FAST:  if (speed_q != SPEED_MAX) speed_d = speed_q + 1'b1;
                IR_CODE_SLOW:  if (speed_q != '0) speed_d = speed_q - 1'b1;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            motion_q <= MOTION_STOP;
            speed_q  <= SPEED_INIT;
            auto_q   <= 1'b0;
            last_q   <= IR_CODE_STOP;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            motion_q <= motion_d;
            speed_q  <= speed_d;
            auto_q   <= auto_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign motion    = motion_q;
    assign speed     = speed_q;
    assign auto_mode = auto_q;
    assign cmd_valid = valid_q;
    assign cmd_error = error_q;

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Scoreboard bench for ir_cmd_decoder: expectations queued at drive time, popped after each edge.
module tb_ir_cmd_decoder;
    import ir_pkg::*;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir_data = '0;
    logic        data_ready = 1'b0;
    logic        ir_repeat = 1'b0;
    motion_t     motion;
    logic [1:0]  speed;
    logic        auto_mode, cmd_valid, cmd_error;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string tag;
        int    m, s, a, v, e;
    } exp_t;
    exp_t sb[$];

    ir_cmd_decoder #(
        .SPEED_LEVELS(4), .SPEED_RESET(0), .TIMEOUT_CYCLES(TO), .ADDR(16'h00FF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ir_data(ir_data), .data_ready(data_ready),
        .ir_repeat(ir_repeat), .motion(motion), .speed(speed), .auto_mode(auto_mode),
        .cmd_valid(cmd_valid), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] c);
`ifdef IR_CMD_CHECK_EN
        return {16'h00FF, ~c, c};
`else
        return {16'($urandom), 8'($urandom), c};
`endif
    endfunction

    task automatic push(input string tag, input int m, input int s, input int a,
                        input int v, input int e);
        exp_t x;
        x.tag = tag; x.m = m; x.s = s; x.a = a; x.v = v; x.e = e;
        sb.push_back(x);
    endtask

    // Drive one cycle of strobes from a negedge and queue the post-edge expectation.
    task automatic send(input logic dr, input logic rep, input logic [31:0] d,
                        input string tag, input int m, input int s, input int a,
                        input int v, input int e);
        data_ready = dr;
        ir_repeat  = rep;
        ir_data    = d;
        push(tag, m, s, a, v, e);
        @(negedge clk);
        data_ready = 1'b0;
        ir_repeat  = 1'b0;
    endtask

    task automatic idle_chk(input string tag, input int m, input int s, input int a,
                            input int v, input int e);
        push(tag, m, s, a, v, e);
        @(negedge clk);
    endtask

    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            $display("txn %-12s motion=%0d speed=%0d auto=%0d valid=%0d err=%0d",
                     x.tag, int'(motion), speed, auto_mode, cmd_valid, cmd_error);
            check_eq({x.tag, ".motion"}, int'(motion), x.m);
            check_eq({x.tag, ".speed"},  int'(speed), x.s);
            check_eq({x.tag, ".auto"},   int'(auto_mode), x.a);
            check_eq({x.tag, ".valid"},  int'(cmd_valid), x.v);
            check_eq({x.tag, ".error"},  int'(cmd_error), x.e);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst.motion", int'(motion), 0);
        check_eq("rst.speed",  int'(speed), 0);
        check_eq("rst.auto",   int'(auto_mode), 0);
        check_eq("rst.valid",  int'(cmd_valid), 0);
        check_eq("rst.error",  int'(cmd_error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First frame, then the pulse must drop after one cycle.
`ifdef IR_CMD_CHECK_EN
        send(1, 0, mk(8'h16), "fwd", 1, 0, 0, 1, 0);
`else
        send(1, 0, 32'h0000F316, "fwd", 1, 0, 0, 1, 0);
`endif
        idle_chk("fwd_after", 1, 0, 0, 0, 0);

        // Saturating speed, back-to-back strobes.
        for (int i = 0; i < 5; i++)
            send(1, 0, mk(8'h1B), "fast", 1, (i < 3) ? i + 1 : 3, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            send(1, 0, mk(8'h1F), "slow", 1, (i < 2) ? 2 - i : 0, 0, 1, 0);

        // Key hold with repeats every 100 cycles, then release after TO cycles.
        send(1, 0, mk(8'h0C), "stop", 0, 0, 0, 1, 0);
        send(1, 0, mk(8'h16), "hold_fwd", 1, 0, 0, 1, 0);
        for (int r = 0; r < 3; r++) begin
            repeat (98) @(negedge clk);
            idle_chk("hold_mid", 1, 0, 0, 0, 0);
            send(0, 1, '0, "hold_rep", 1, 0, 0, 1, 0);
        end
        repeat (TO - 2) @(negedge clk);
        idle_chk("pre_timeout", 1, 0, 0, 0, 0);
        idle_chk("timeout", 0, 0, 0, 0, 0);

        // Repeat while idle is ignored; unknown codes flag an error.
        send(0, 1, '0, "idle_rep", 0, 0, 0, 0, 0);
        send(1, 0, mk(8'h55), "unknown", 0, 0, 0, 0, 1);
        send(1, 0, mk(8'h16), "fwd2", 1, 0, 0, 1, 0);
        send(1, 0, mk(8'h00), "unk_held", 0, 0, 0, 0, 1);
        idle_chk("unk_after", 0, 0, 0, 0, 0);

        // Auto mode masks motion commands.
        send(1, 0, mk(8'h12), "toggle_on", 0, 0, 1, 1, 0);
        send(1, 0, mk(8'h14), "auto_left", 0, 0, 1, 0, 0);
        send(1, 0, mk(8'h1B), "auto_fast", 0, 0, 1, 0, 0);
        send(0, 1, '0, "auto_rep", 0, 0, 1, 0, 0);
        send(1, 0, mk(8'h0C), "auto_stop", 0, 0, 1, 1, 0);
        send(1, 0, mk(8'h12), "toggle_off", 0, 0, 0, 1, 0);

        // Frame wins over a simultaneous repeat.
        send(1, 0, mk(8'h1B), "hold_fast", 0, 1, 0, 1, 0);
        send(1, 1, mk(8'h18), "frame_wins", 3, 1, 0, 1, 0);
        idle_chk("fw_after", 3, 1, 0, 0, 0);

        // Restart on the expiry cycle keeps the command alive.
        send(1, 0, mk(8'h16), "exp_fwd", 1, 1, 0, 1, 0);
        repeat (TO - 1) @(negedge clk);
        send(0, 1, '0, "exp_restart", 1, 1, 0, 1, 0);
        idle_chk("exp_after", 1, 1, 0, 0, 0);

        // Frame integrity: only enforced with the check build.
`ifdef IR_CMD_CHECK_EN
        send(1, 0, 32'h00FF0014, "bad_cmpl", 0, 1, 0, 0, 1);
        send(1, 0, 32'h00FEEB14, "bad_addr", 0, 1, 0, 0, 1);
`else
        send(1, 0, 32'h00FF0014, "upper_ign", 2, 1, 0, 1, 0);
        send(1, 0, 32'h00FEEB14, "upper_ign2", 2, 1, 0, 1, 0);
`endif
        send(1, 0, 32'h00FFEB14, "good_left", 2, 1, 0, 1, 0);

        // Asynchronous reset while held clears everything immediately.
        send(1, 0, mk(8'h1B), "pre_rst", 2, 2, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst.motion", int'(motion), 0);
        check_eq("async_rst.speed",  int'(speed), 0);
        check_eq("async_rst.valid",  int'(cmd_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TO + 100) @(negedge clk);
        idle_chk("post_rst", 0, 0, 0, 0, 0);
        send(0, 1, '0, "post_rst_rep", 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_cmd_decoder.md
# ir_cmd_decoder

Parametrised IR remote command decoder. It turns validated 32-bit NEC frames and repeat codes from the IR receiver into registered motion, speed-level and mode outputs for the UART/JSON motor command path. Compared with the single-shot controller, it adds:
- a saturating multi-level speed setting;
- key-hold via repeat codes, with an automatic STOP when the hold timer expires;
- a manual/auto mode flag that masks motion commands;
- a frame validity check that can be compiled in or out.

## Interface
Parameters:
- SPEED_LEVELS, 4, number of speed levels (≥2); speed output range 0..SPEED_LEVELS-1
- SPEED_RESET, 0, speed level after reset (< SPEED_LEVELS)
- TIMEOUT_CYCLES, 5_400_000, cycles without frame/repeat before a held command is released (108 ms @ 50 MHz)
- ADDR, 16'h00FF, expected remote address in ir_data[31:16] (used only with IR_CMD_CHECK_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ir_data  in  32  frame: [7:0] command, [15:8] ~command, [31:16] address
- data_ready  in  1  one-cycle strobe, ir_data valid
- ir_repeat  in  1  one-cycle strobe, NEC repeat code received
- motion  out  3  motion_t: STOP=0, FWD=1, LEFT=2, RIGHT=3
- speed  out  $clog2(SPEED_LEVELS)  current speed level
- auto_mode  out  1  1 = autonomous mode, manual motion masked
- cmd_valid  out  1  one-cycle pulse, a frame or repeat was applied
- cmd_error  out  1  one-cycle pulse, frame rejected (unknown code or failed check)

## Operation
- Command codes:
  - 8'h0C STOP
  - 8'h16 FWD
  - 8'h14 LEFT
  - 8'h18 RIGHT
  - 8'h1B FAST: speed+1, saturates at SPEED_LEVELS-1
  - 8'h1F SLOW: speed-1, saturates at 0
  - 8'h12 TOGGLE: flip auto_mode
- FSM states: IDLE (no held command), HELD (last_cmd latched, hold timer running).
- Accepted FWD/LEFT/RIGHT/FAST/SLOW frame:
  - apply the command and latch last_cmd;
  - go to HELD and restart the timer;
  - pulse cmd_valid.
- STOP frame: motion=STOP; go to IDLE; pulse cmd_valid.
- TOGGLE frame:
  - flip auto_mode and force motion=STOP;
  - go to IDLE; pulse cmd_valid;
  - TOGGLE is never latched as last_cmd.
- ir_repeat behaviour:
  - in HELD: re-apply last_cmd (FAST/SLOW step speed again), restart the timer, pulse cmd_valid;
  - in IDLE: ignored, no pulses.
- Timer expiry in HELD: motion=STOP, go to IDLE, no pulse. Speed is retained.
- Unknown code: motion=STOP, go to IDLE, pulse cmd_error.
- auto_mode=1:
  - only STOP and TOGGLE are acted on;
  - FWD/LEFT/RIGHT/FAST/SLOW frames and repeats are ignored silently (no pulses, state unchanged);
  - motion held at STOP.

## Timing
- Reset values: motion=STOP, speed=SPEED_RESET, auto_mode=0, cmd_valid=0, cmd_error=0, FSM=IDLE.
- All outputs are registered. A strobe in cycle n gives updated outputs and pulses in cycle n+1, and pulses last exactly one cycle.
- data_ready and ir_repeat in the same cycle: the frame wins and the repeat is dropped.
- Hold timer:
  - width $clog2(TIMEOUT_CYCLES+1);
  - loads 0 on restart and counts every cycle in HELD;
  - at count TIMEOUT_CYCLES-1, motion=STOP is visible on the next cycle.
- A restart on the expiry cycle wins: the command is re-applied and no STOP occurs.
- Back-to-back strobes on consecutive cycles are each applied. There is no buffering and no lost strobes.
- rst_n asserted mid-hold returns to reset values immediately (asynchronous), and the timer clears.

## Configuration
- IR_CMD_CHECK_EN defined:
  - a frame is accepted only if ir_data[15:8]==~ir_data[7:0] and ir_data[31:16]==ADDR;
  - failure gives cmd_error and motion=STOP, same as an unknown code.
- IR_CMD_CHECK_EN undefined: only ir_data[7:0] is decoded, upper bits are ignored, and ADDR is unused.

## Structure
- Shared package ir_pkg holds:
  - motion_t enum;
  - command code localparams (IR_CODE_STOP … IR_CODE_TOGGLE);
  - hold state enum {IDLE, HELD}.
- Sub-module ir_hold_timer (parameter TIMEOUT_CYCLES; ports clk, rst_n, restart, run, expire) holds the counter. The decoder FSM stays in ir_cmd_decoder.

## Test plan
- Reset, then frame 0x0000F316 (FWD, checks disabled) → next cycle motion=FWD, cmd_valid=1 for one cycle.
- FAST frame ×5 with SPEED_LEVELS=4, SPEED_RESET=0 → speed 1,2,3,3,3. Then SLOW ×4 → 2,1,0,0.
- FWD frame, then ir_repeat every 100 cycles with TIMEOUT_CYCLES=200 → motion stays FWD. Stop the repeats → motion=STOP exactly 200 cycles after the last restart.
- TOGGLE frame → auto_mode=1, motion=STOP. Then a LEFT frame → no change, no pulses. Then TOGGLE → auto_mode=0.
- With IR_CMD_CHECK_EN: frame 0x00FF0014 (bad complement) → cmd_error=1, motion=STOP. Frame 0x00FFEB14 → motion=LEFT.
- data_ready and ir_repeat together while HELD on FAST with frame RIGHT → motion=RIGHT, speed unchanged, single cmd_valid.
